// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the core-local interrupt arbiter: data width,
// mcause codes, FSM state encoding and the cause/priority helpers.
package int_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int IRQ_FLAG_BIT = XLEN - 1;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_e;

  // Interrupt flag in the top bit, exception code in the low nibble.
  function automatic logic [XLEN-1:0] make_cause(input logic [3:0] code);
    return {1'b1, {(XLEN-5){1'b0}}, code};
  endfunction

  // Eligible vector is {MEI, MTI, MSI}; RISC-V order is MEI > MSI > MTI.
  function automatic logic [3:0] pick_code(input logic [2:0] elig);
    logic [3:0] code;
    if (elig[2]) begin
      code = CAUSE_MEI;
    end else if (elig[0]) begin
      code = CAUSE_MSI;
    end else if (elig[1]) begin
      code = CAUSE_MTI;
    end else begin
      code = 4'd0;
    end
    return code;
  endfunction

  function automatic logic [2:0] code_mask(input logic [3:0] code);
    logic [2:0] mask;
    case (code)
      CAUSE_MEI: mask = 3'b100;
      CAUSE_MTI: mask = 3'b010;
      CAUSE_MSI: mask = 3'b001;
      default:   mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// Interrupt source / trap-request bundle between the timer block, the CSR
// file and the core; slave is the arbiter's view, master the core side.
interface int_arbiter_if;
  import int_arbiter_pkg::*;

  logic            int_timer;
  logic            int_soft;
  logic            int_ext;
  logic [2:0]      mie;
  logic            mstatus_mie;
  logic            irq_ack;
  logic            mret;
  logic [2:0]      mip;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;

  modport master (
    output int_timer, int_soft, int_ext, mie, mstatus_mie, irq_ack, mret,
    input  mip, irq_req, irq_cause
  );

  modport slave (
    input  int_timer, int_soft, int_ext, mie, mstatus_mie, irq_ack, mret,
    output mip, irq_req, irq_cause
  );

endinterface

// File: rtl/int_sync.sv
// External interrupt synchroniser with optional rising-edge pending latch;
// produces the MEIP bit. Set beats clear when both land in one cycle.
module int_sync #(
  parameter int STAGES = 2,
  parameter bit EDGE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic clr,
  output logic meip
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;
  logic              pend_r;
  logic              ext_s;
  logic              rise_s;

  assign ext_s  = sync_r[STAGES-1];
  assign rise_s = ext_s & ~hist_r;

  // Synchroniser chain, edge history and pending latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
      hist_r <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      hist_r <= ext_s;
      pend_r <= rise_s | (pend_r & ~clr);
    end
  end

  // Level mode exposes the synchronised line, edge mode the latch.
  always_comb begin
    if (EDGE) begin
      meip = pend_r;
    end else begin
      meip = ext_s;
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Core-local interrupt arbiter: masks and prioritises MEI/MSI/MTI and runs a
// request/ack/mret handshake so only one trap is outstanding at a time.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int EXT_SYNC = 2,
  parameter int EXT_EDGE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  int_arbiter_if.slave  bus
);

  arb_state_e      state_r;
  arb_state_e      state_next_s;
  logic [3:0]      code_r;
  logic [3:0]      code_next_s;
  logic [XLEN-1:0] cause_r;
  logic            irq_req_r;
  logic            meip_s;
  logic            clr_ext_s;
  logic            load_s;
  logic [2:0]      mip_s;
  logic [2:0]      elig_s;

  // Edge-mode MEIP is only retired by an ack of the request it raised.
  assign clr_ext_s = (state_r == ST_REQ) && bus.irq_ack && (code_r == CAUSE_MEI);

  int_sync #(
    .STAGES (EXT_SYNC),
    .EDGE   (EXT_EDGE != 0)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.int_ext),
    .clr      (clr_ext_s),
    .meip     (meip_s)
  );

  assign mip_s         = {meip_s, bus.int_timer, bus.int_soft};
  assign elig_s        = mip_s & bus.mie & {3{bus.mstatus_mie}};
  assign load_s        = (state_r == ST_IDLE) && (state_next_s == ST_REQ);
  assign bus.mip       = mip_s;
  assign bus.irq_req   = irq_req_r;
  assign bus.irq_cause = cause_r;

  // Next-state logic; ack takes priority over withdrawal in REQ.
  always_comb begin
    state_next_s = state_r;
    code_next_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (elig_s != 3'b000) begin
          state_next_s = ST_REQ;
          code_next_s  = pick_code(elig_s);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          state_next_s = ST_SERVICE;
        end else if ((elig_s & code_mask(code_r)) == 3'b000) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (bus.mret) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SERVICE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, latched code and registered request/cause outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      code_r    <= 4'd0;
      irq_req_r <= 1'b0;
      cause_r   <= {XLEN{1'b0}};
    end else begin
      state_r   <= state_next_s;
      code_r    <= code_next_s;
      irq_req_r <= (state_next_s == ST_REQ);
      if (load_s) begin
        cause_r <= make_cause(code_next_s);
      end else begin
        cause_r <= cause_r;
      end
    end
  end

endmodule
